// File: rtl/sccb_ov7670_cfg_ctrl_if.sv
// rtl/sccb_ov7670_cfg_ctrl_if.sv - LUT walk and status bundle between the OV7670 config LUT and the SCCB sequencer
interface sccb_ov7670_cfg_ctrl_if;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        cfg_done;
  logic        id_ok;
  logic        ack_err;

  modport master (output lut_index, cfg_done, id_ok, ack_err, input lut_data);
  modport slave  (input lut_index, cfg_done, id_ok, ack_err, output lut_data);
endinterface

// File: rtl/sccb_ov7670_cfg_ctrl.sv
// rtl/sccb_ov7670_cfg_ctrl.sv - OV7670 bring-up sequencer and SCCB master
// Walks the config LUT: leading entries are ID reads, the rest register writes.
module sccb_ov7670_cfg_ctrl #(
  parameter int unsigned SCL_QDIV      = 62,
  parameter int unsigned PWR_DELAY_CYC = 25000,
  parameter int unsigned GAP_CYC       = 250,
  parameter int unsigned LUT_SIZE      = 173,
  parameter int unsigned READ_NUM      = 2,
  parameter logic [7:0]  DEV_ADDR      = 8'h42
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sccb_ov7670_cfg_ctrl_if.master cfg,
  output logic                   sccb_sclk,
  inout  wire                    sccb_sdat
);
  typedef enum logic [2:0] {S_PWR_WAIT, S_LOAD, S_START_TX, S_XFER, S_GAP, S_DONE} state_e;
  typedef enum logic [1:0] {E_START, E_BIT, E_STOP} elem_e;

  localparam int unsigned CNT_W = $clog2(PWR_DELAY_CYC + GAP_CYC + 2);
  localparam int unsigned QD_W  = (SCL_QDIV > 1) ? $clog2(SCL_QDIV) : 1;

  state_e           state_q;
  elem_e            elem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [QD_W-1:0]  qdiv_q;
  logic [1:0]       quarter_q;
  logic [3:0]       bitn_q;
  logic [1:0]       byten_q;
  logic             phase2_q, is_read_q;
  logic [7:0]       lut_index_q;
  logic [15:0]      data_q;
  logic [7:0]       rd_byte_q;
  logic [1:0]       sda_sync_q;
  logic             sclk_q, sda_low_q, match_q, id_ok_q, ack_err_q, done_q;

  logic       tick, ack_slot, rd_slot, tx_bit, last_read, match_d;
  logic [7:0] tx_byte;
  logic [1:0] last_byte;

  always_comb begin
    tick      = (state_q == S_XFER) && (qdiv_q == QD_W'(SCL_QDIV - 1));
    last_byte = is_read_q ? 2'd1 : 2'd2;
    rd_slot   = phase2_q && (byten_q == 2'd1) && (bitn_q != 4'd8);
    ack_slot  = (bitn_q == 4'd8) && !(phase2_q && (byten_q == 2'd1));
    // Read data bytes and every 9th bit leave SDA released
    if (phase2_q)              tx_byte = (byten_q == 2'd0) ? (DEV_ADDR | 8'h01) : 8'hFF;
    else if (byten_q == 2'd0)  tx_byte = DEV_ADDR;
    else if (byten_q == 2'd1)  tx_byte = data_q[15:8];
    else                       tx_byte = data_q[7:0];
    tx_bit    = (bitn_q == 4'd8) ? 1'b1 : tx_byte[3'd7 - bitn_q[2:0]];
    last_read = is_read_q && (32'(lut_index_q) == READ_NUM - 1);
    match_d   = match_q & (rd_byte_q == data_q[7:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWR_WAIT;
      elem_q      <= E_START;
      cnt_q       <= '0;
      qdiv_q      <= '0;
      quarter_q   <= 2'd0;
      bitn_q      <= 4'd0;
      byten_q     <= 2'd0;
      phase2_q    <= 1'b0;
      is_read_q   <= 1'b0;
      lut_index_q <= 8'd0;
      data_q      <= 16'd0;
      rd_byte_q   <= 8'd0;
      sda_sync_q  <= 2'b11;
      sclk_q      <= 1'b1;
      sda_low_q   <= 1'b0;
      match_q     <= 1'b0;
      id_ok_q     <= 1'b0;
      ack_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sda_sync_q <= {sda_sync_q[0], sccb_sdat};
      qdiv_q     <= (state_q == S_XFER && !tick) ? qdiv_q + QD_W'(1) : '0;
      unique case (state_q)
        S_PWR_WAIT: begin
          if (cnt_q == CNT_W'(PWR_DELAY_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_LOAD: begin
          data_q  <= cfg.lut_data;
          if (lut_index_q == 8'd0) match_q <= 1'b1;
          state_q <= S_START_TX;
        end
        S_START_TX: begin
          is_read_q <= (32'(lut_index_q) < READ_NUM);
          elem_q    <= E_START;
          quarter_q <= 2'd0;
          bitn_q    <= 4'd0;
          byten_q   <= 2'd0;
          phase2_q  <= 1'b0;
          state_q   <= S_XFER;
        end
        S_XFER: if (tick) begin
          quarter_q <= quarter_q + 2'd1;
          unique case (elem_q)
            E_START: begin
              case (quarter_q)
                2'd0:    begin sclk_q <= 1'b1; sda_low_q <= 1'b0; end
                2'd1:    sda_low_q <= 1'b1;
                2'd2:    sclk_q <= 1'b0;
                default: begin elem_q <= E_BIT; bitn_q <= 4'd0; byten_q <= 2'd0; end
              endcase
            end
            E_BIT: begin
              case (quarter_q)
                2'd0:    sda_low_q <= ~tx_bit;
                2'd1:    sclk_q <= 1'b1;
                2'd2: begin
                  // SCCB treats ACK as don't-care: flag it but keep going
                  if (ack_slot && sda_sync_q[1]) ack_err_q <= 1'b1;
                  if (rd_slot) rd_byte_q <= {rd_byte_q[6:0], sda_sync_q[1]};
                end
                default: begin
                  sclk_q <= 1'b0;
                  if (bitn_q != 4'd8) begin
                    bitn_q <= bitn_q + 4'd1;
                  end else begin
                    bitn_q <= 4'd0;
                    if (byten_q == last_byte) elem_q <= E_STOP;
                    else                      byten_q <= byten_q + 2'd1;
                  end
                end
              endcase
            end
            default: begin
              case (quarter_q)
                2'd0:    sda_low_q <= 1'b1;
                2'd1:    sclk_q <= 1'b1;
                2'd2:    sda_low_q <= 1'b0;
                default: begin
                  if (is_read_q && !phase2_q) begin
                    phase2_q <= 1'b1;
                    elem_q   <= E_START;
                  end else begin
                    if (is_read_q) match_q <= match_d;
                    if (last_read) id_ok_q <= match_d;
                    cnt_q   <= '0;
                    state_q <= S_GAP;
                  end
                end
              endcase
            end
          endcase
        end
        S_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
            cnt_q <= '0;
            if (lut_index_q == 8'(LUT_SIZE - 1)) begin
              done_q  <= 1'b1;
              if (READ_NUM == 0) id_ok_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              lut_index_q <= lut_index_q + 8'd1;
              state_q     <= S_LOAD;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sccb_sclk     = sclk_q;
  assign sccb_sdat     = sda_low_q ? 1'b0 : 1'bz;
  assign cfg.lut_index = lut_index_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.id_ok     = id_ok_q;
  assign cfg.ack_err   = ack_err_q;
endmodule
